wb_retire_stage: RTL and testbench

Parametrised writeback/retire stage, the final pipeline stage after the memory stage. It commits results to the register file and drives the CSR unit through an external port instead of an embedded instance. It handles exceptions carried down the pipe, external interrupts and ERTN, and owns a redirect FSM that squashes wrong-path instructions until fetch accepts the new PC. It also keeps a retired-instruction counter and drives the trace debug port.

---
 rtl/wb_retire_stage_pkg.sv | 22 ++
 rtl/wb_redirect_fsm.sv | 62 ++++++
 rtl/wb_retire_stage.sv | 155 +++++++++++++++
 tb/tb_wb_retire_stage.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_retire_stage_pkg.sv
// Shared definitions for the writeback/retire stage.
//   - Default widths for the stage parameters.
//   - Exception codes that the stage generates itself.
//   - Redirect FSM state encoding.
package wb_retire_stage_pkg;

  localparam int XLEN_DEF      = 32;
  localparam int RADDR_W_DEF   = 5;
  localparam int CSR_NUM_W_DEF = 14;
  localparam int ECODE_W_DEF   = 6;
  localparam int ESUB_W_DEF    = 9;
  localparam int CNT_W_DEF     = 64;

  localparam logic [5:0] ECODE_INT = 6'h0;
  localparam logic [5:0] ECODE_SYS = 6'hB;

  typedef enum logic {
    WS_RUN      = 1'b0,
    WS_REDIRECT = 1'b1
  } ws_state_e;

endpackage

// File: rtl/wb_redirect_fsm.sv
// Redirect FSM for the retire stage.
// A flush taken in RUN latches the target PC and moves to REDIRECT. In
// REDIRECT, redirect_valid is held with a stable PC until fetch accepts it.
// Ports:
//   clk, reset       : clock, synchronous active-high reset
//   flush, sel_ex    : flush this cycle; target is ex_entry (1) or era (0)
//   ex_entry, era    : candidate redirect targets, sampled in the flush cycle
//   redirect_ready   : fetch accepts the redirect
//   run              : FSM is in RUN (stage may accept instructions)
//   redirect_valid/pc: redirect request to fetch
module wb_redirect_fsm
  import wb_retire_stage_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            sel_ex,
  input  logic [XLEN-1:0] ex_entry,
  input  logic [XLEN-1:0] era,
  input  logic            redirect_ready,
  output logic            run,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc
);

  ws_state_e       state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    case (state_q)
      WS_RUN: begin
        if (flush) begin
          state_d = WS_REDIRECT;
          pc_d    = sel_ex ? ex_entry : era;
        end
      end
      WS_REDIRECT: begin
        if (redirect_ready) state_d = WS_RUN;
      end
      default: state_d = WS_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= WS_RUN;
      pc_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  assign run            = (state_q == WS_RUN);
  assign redirect_valid = (state_q == WS_REDIRECT);
  assign redirect_pc    = pc_q;

endmodule

// File: rtl/wb_retire_stage.sv
// Writeback/retire stage: final pipeline stage after MEM.
// Commits GR writes, drives the external CSR port, resolves interrupts,
// exceptions and ERTN, squashes wrong-path work via a redirect FSM, counts
// retired instructions and mirrors RF writes onto the trace debug port.
// Ports:
//   ms_*           : instruction payload from the memory stage
//   has_int        : pending enabled interrupt
//   csr_*          : CSR unit access (csr_rvalue/ex_entry/era come back in)
//   wb_*/ertn_flush: exception/ERTN commit to the CSR unit
//   ws_flush_pipe  : squash all earlier stages this cycle
//   redirect_*     : fetch redirect handshake
//   ws_to_rf_*     : register file write port
//   instret        : retired-instruction counter
//   debug_wb_*     : trace port
module wb_retire_stage
  import wb_retire_stage_pkg::*;
#(
  parameter int XLEN      = XLEN_DEF,
  parameter int RADDR_W   = RADDR_W_DEF,
  parameter int CSR_NUM_W = CSR_NUM_W_DEF,
  parameter int ECODE_W   = ECODE_W_DEF,
  parameter int ESUB_W    = ESUB_W_DEF,
  parameter int CNT_W     = CNT_W_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 ms_to_ws_valid,
  output logic                 ws_allowin,
  input  logic [XLEN-1:0]      ms_pc,
  input  logic [XLEN-1:0]      ms_result,
  input  logic                 ms_gr_we,
  input  logic [RADDR_W-1:0]   ms_dest,
  input  logic                 ms_csr_re,
  input  logic                 ms_csr_we,
  input  logic [CSR_NUM_W-1:0] ms_csr_num,
  input  logic [XLEN-1:0]      ms_csr_wmask,
  input  logic [XLEN-1:0]      ms_csr_wvalue,
  input  logic                 ms_ex,
  input  logic [ECODE_W-1:0]   ms_ecode,
  input  logic [ESUB_W-1:0]    ms_esubcode,
  input  logic                 ms_ertn,
  input  logic                 has_int,
  output logic                 csr_re,
  output logic                 csr_we,
  output logic [CSR_NUM_W-1:0] csr_num,
  output logic [XLEN-1:0]      csr_wmask,
  output logic [XLEN-1:0]      csr_wvalue,
  input  logic [XLEN-1:0]      csr_rvalue,
  input  logic [XLEN-1:0]      csr_ex_entry,
  input  logic [XLEN-1:0]      csr_era,
  output logic                 wb_ex,
  output logic [ECODE_W-1:0]   wb_ecode,
  output logic [ESUB_W-1:0]    wb_esubcode,
  output logic [XLEN-1:0]      wb_pc,
  output logic                 ertn_flush,
  output logic                 ws_flush_pipe,
  output logic                 redirect_valid,
  output logic [XLEN-1:0]      redirect_pc,
  input  logic                 redirect_ready,
  output logic                 ws_to_rf_we,
  output logic [RADDR_W-1:0]   ws_to_rf_waddr,
  output logic [XLEN-1:0]      ws_to_rf_wdata,
  output logic [CNT_W-1:0]     instret,
  output logic [XLEN-1:0]      debug_wb_pc,
  output logic [XLEN/8-1:0]    debug_wb_rf_wen,
  output logic [RADDR_W-1:0]   debug_wb_rf_wnum,
  output logic [XLEN-1:0]      debug_wb_rf_wdata
);

  localparam int PL_W = 4*XLEN + RADDR_W + CSR_NUM_W + ECODE_W + ESUB_W + 5;

  logic             ws_valid_q, ws_valid_d;
  logic [PL_W-1:0]  pl_q, pl_d;
  logic [CNT_W-1:0] instret_q, instret_d;
  logic             fsm_run, accept, int_take, retire;

  logic [XLEN-1:0]      pc_f, result_f, csr_wmask_f, csr_wvalue_f;
  logic                 gr_we_f, csr_re_f, csr_we_f, ex_f, ertn_f;
  logic [RADDR_W-1:0]   dest_f;
  logic [CSR_NUM_W-1:0] csr_num_f;
  logic [ECODE_W-1:0]   ecode_f;
  logic [ESUB_W-1:0]    esub_f;

  assign {pc_f, result_f, gr_we_f, dest_f, csr_re_f, csr_we_f, csr_num_f,
          csr_wmask_f, csr_wvalue_f, ex_f, ecode_f, esub_f, ertn_f} = pl_q;

  // Always ready; in REDIRECT (and in a flush cycle, where MS holds a
  // wrong-path instruction) arrivals are consumed and discarded.
  assign ws_allowin = 1'b1;
  assign accept     = ms_to_ws_valid && ws_allowin && fsm_run && !ws_flush_pipe;

  always_comb begin
    ws_valid_d = accept;
    pl_d       = pl_q;
    if (accept)
      pl_d = {ms_pc, ms_result, ms_gr_we, ms_dest, ms_csr_re, ms_csr_we,
              ms_csr_num, ms_csr_wmask, ms_csr_wvalue, ms_ex, ms_ecode,
              ms_esubcode, ms_ertn};
  end

  // Interrupt > upstream exception > ERTN.
  assign int_take      = ws_valid_q && has_int;
  assign wb_ex         = ws_valid_q && (int_take || ex_f);
  assign wb_ecode      = int_take ? ECODE_W'(ECODE_INT) : ecode_f;
  assign wb_esubcode   = int_take ? '0 : esub_f;
  assign wb_pc         = pc_f;
  assign ertn_flush    = ws_valid_q && ertn_f && !wb_ex;
  assign ws_flush_pipe = wb_ex || ertn_flush;

  assign csr_re     = ws_valid_q && (csr_re_f || ertn_f);
  assign csr_we     = ws_valid_q && csr_we_f && !wb_ex;
  assign csr_num    = csr_num_f;
  assign csr_wmask  = csr_wmask_f;
  assign csr_wvalue = csr_wvalue_f;

  assign ws_to_rf_we    = ws_valid_q && (gr_we_f || csr_re_f) && !wb_ex;
  assign ws_to_rf_waddr = dest_f;
  assign ws_to_rf_wdata = csr_re_f ? csr_rvalue : result_f;

  assign debug_wb_pc       = pc_f;
  assign debug_wb_rf_wen   = {(XLEN/8){ws_to_rf_we}};
  assign debug_wb_rf_wnum  = dest_f;
  assign debug_wb_rf_wdata = ws_to_rf_wdata;

  // ERTN counts as retired; excepting instructions do not.
  assign retire    = ws_valid_q && !wb_ex;
  assign instret_d = instret_q + CNT_W'(retire);
  assign instret   = instret_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      ws_valid_q <= 1'b0;
      pl_q       <= '0;
      instret_q  <= '0;
    end else begin
      ws_valid_q <= ws_valid_d;
      pl_q       <= pl_d;
      instret_q  <= instret_d;
    end
  end

  wb_redirect_fsm #(.XLEN(XLEN)) u_redirect_fsm (
    .clk            (clk),
    .reset          (reset),
    .flush          (ws_flush_pipe),
    .sel_ex         (wb_ex),
    .ex_entry       (csr_ex_entry),
    .era            (csr_era),
    .redirect_ready (redirect_ready),
    .run            (fsm_run),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc)
  );

endmodule

// File: tb/tb_wb_retire_stage.sv
module tb_wb_retire_stage;
  import wb_retire_stage_pkg::*;

  localparam int XLEN = 32, RADDR_W = 5, CSR_NUM_W = 14;
  localparam int ECODE_W = 6, ESUB_W = 9, CNT_W = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic ms_to_ws_valid, ws_allowin;
  logic [XLEN-1:0] ms_pc, ms_result, ms_csr_wmask, ms_csr_wvalue;
  logic ms_gr_we, ms_csr_re, ms_csr_we, ms_ex, ms_ertn, has_int;
  logic [RADDR_W-1:0] ms_dest;
  logic [CSR_NUM_W-1:0] ms_csr_num;
  logic [ECODE_W-1:0] ms_ecode;
  logic [ESUB_W-1:0] ms_esubcode;
  logic csr_re, csr_we;
  logic [CSR_NUM_W-1:0] csr_num;
  logic [XLEN-1:0] csr_wmask, csr_wvalue, csr_rvalue, csr_ex_entry, csr_era;
  logic wb_ex, ertn_flush, ws_flush_pipe, redirect_valid, redirect_ready;
  logic [ECODE_W-1:0] wb_ecode;
  logic [ESUB_W-1:0] wb_esubcode;
  logic [XLEN-1:0] wb_pc, redirect_pc, ws_to_rf_wdata, debug_wb_pc, debug_wb_rf_wdata;
  logic ws_to_rf_we;
  logic [RADDR_W-1:0] ws_to_rf_waddr, debug_wb_rf_wnum;
  logic [CNT_W-1:0] instret;
  logic [XLEN/8-1:0] debug_wb_rf_wen;

  typedef struct {
    logic [RADDR_W-1:0] waddr;
    logic [XLEN-1:0]    wdata;
  } rf_exp_t;

  rf_exp_t sb[$];
  int n_pass = 0;
  int n_tot  = 0;

  always #5 clk = ~clk;

  wb_retire_stage #(
    .XLEN(XLEN), .RADDR_W(RADDR_W), .CSR_NUM_W(CSR_NUM_W),
    .ECODE_W(ECODE_W), .ESUB_W(ESUB_W), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset(reset),
    .ms_to_ws_valid(ms_to_ws_valid), .ws_allowin(ws_allowin),
    .ms_pc(ms_pc), .ms_result(ms_result), .ms_gr_we(ms_gr_we), .ms_dest(ms_dest),
    .ms_csr_re(ms_csr_re), .ms_csr_we(ms_csr_we), .ms_csr_num(ms_csr_num),
    .ms_csr_wmask(ms_csr_wmask), .ms_csr_wvalue(ms_csr_wvalue),
    .ms_ex(ms_ex), .ms_ecode(ms_ecode), .ms_esubcode(ms_esubcode), .ms_ertn(ms_ertn),
    .has_int(has_int),
    .csr_re(csr_re), .csr_we(csr_we), .csr_num(csr_num),
    .csr_wmask(csr_wmask), .csr_wvalue(csr_wvalue), .csr_rvalue(csr_rvalue),
    .csr_ex_entry(csr_ex_entry), .csr_era(csr_era),
    .wb_ex(wb_ex), .wb_ecode(wb_ecode), .wb_esubcode(wb_esubcode), .wb_pc(wb_pc),
    .ertn_flush(ertn_flush), .ws_flush_pipe(ws_flush_pipe),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .redirect_ready(redirect_ready),
    .ws_to_rf_we(ws_to_rf_we), .ws_to_rf_waddr(ws_to_rf_waddr),
    .ws_to_rf_wdata(ws_to_rf_wdata), .instret(instret),
    .debug_wb_pc(debug_wb_pc), .debug_wb_rf_wen(debug_wb_rf_wen),
    .debug_wb_rf_wnum(debug_wb_rf_wnum), .debug_wb_rf_wdata(debug_wb_rf_wdata)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tot++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
  endtask

  // Scoreboard side: any RF write the DUT makes must match the oldest
  // expected write; a write with nothing expected is a failure.
  task automatic rf_mon();
    rf_exp_t e;
    if (ws_to_rf_we === 1'b1) begin
      if (sb.size() == 0) chk("rf_we_unexpected", 64'(ws_to_rf_we), 64'd0);
      else begin
        e = sb.pop_front();
        chk("rf_waddr", 64'(ws_to_rf_waddr), 64'(e.waddr));
        chk("rf_wdata", 64'(ws_to_rf_wdata), 64'(e.wdata));
        chk("dbg_wen",  64'(debug_wb_rf_wen), 64'hF);
        chk("dbg_wnum", 64'(debug_wb_rf_wnum), 64'(e.waddr));
        chk("dbg_wdata", 64'(debug_wb_rf_wdata), 64'(e.wdata));
      end
    end
  endtask

  task automatic cyc();
    rf_mon();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_ms();
    ms_to_ws_valid = 0; ms_pc = '0; ms_result = '0; ms_gr_we = 0; ms_dest = '0;
    ms_csr_re = 0; ms_csr_we = 0; ms_csr_num = '0; ms_csr_wmask = '0;
    ms_csr_wvalue = '0; ms_ex = 0; ms_ecode = '0; ms_esubcode = '0; ms_ertn = 0;
  endtask

  // Present one instruction for one edge; it is in WS on return.
  task automatic send();
    ms_to_ws_valid = 1;
    cyc();
    clr_ms();
  endtask

  task automatic send_add(input logic [XLEN-1:0] pc, input logic [RADDR_W-1:0] d,
                          input logic [XLEN-1:0] res);
    rf_exp_t e;
    e.waddr = d; e.wdata = res;
    sb.push_back(e);
    ms_pc = pc; ms_gr_we = 1; ms_dest = d; ms_result = res;
    send();
  endtask

  task automatic handshake();
    redirect_ready = 1;
    #1;
    chk("hs_redirect_valid", 64'(redirect_valid), 64'd1);
    cyc();
    redirect_ready = 0;
    #1;
    chk("post_hs_redirect_valid", 64'(redirect_valid), 64'd0);
  endtask

  initial begin
    clr_ms();
    has_int = 0; redirect_ready = 0;
    csr_rvalue = 32'hC5C5_0001; csr_ex_entry = 32'h1c00_8000; csr_era = 32'h1c00_0044;

    // Reset
    repeat (3) cyc();
    reset = 0;
    chk("rst_allowin", 64'(ws_allowin), 64'd1);
    chk("rst_instret", 64'(instret), 64'd0);
    chk("rst_redirect_valid", 64'(redirect_valid), 64'd0);
    chk("rst_redirect_pc", 64'(redirect_pc), 64'd0);
    chk("rst_dbg_wen", 64'(debug_wb_rf_wen), 64'd0);
    chk("rst_flush", 64'(ws_flush_pipe), 64'd0);

    // Normal retire
    send_add(32'h1c00_0000, 5'd5, 32'h1234);
    chk("add_rf_we", 64'(ws_to_rf_we), 64'd1);
    chk("add_dbg_pc", 64'(debug_wb_pc), 64'h1c00_0000);
    chk("add_instret_before", 64'(instret), 64'd0);
    cyc();
    chk("add_instret_after", 64'(instret), 64'd1);

    // Syscall with a wrong-path ADD right behind it
    ms_pc = 32'h1c00_0010; ms_ex = 1; ms_ecode = ECODE_SYS;
    send();
    ms_to_ws_valid = 1; ms_pc = 32'h1c00_0014; ms_gr_we = 1; ms_dest = 5'd7;
    ms_result = 32'hDEAD;
    #1;
    chk("sys_wb_ex", 64'(wb_ex), 64'd1);
    chk("sys_ecode", 64'(wb_ecode), 64'hB);
    chk("sys_wb_pc", 64'(wb_pc), 64'h1c00_0010);
    chk("sys_rf_we", 64'(ws_to_rf_we), 64'd0);
    chk("sys_flush", 64'(ws_flush_pipe), 64'd1);
    chk("sys_ertn_flush", 64'(ertn_flush), 64'd0);
    chk("sys_rv_T", 64'(redirect_valid), 64'd0);
    cyc();
    for (int i = 0; i < 3; i++) begin
      chk("sys_redirect_valid", 64'(redirect_valid), 64'd1);
      chk("sys_redirect_pc", 64'(redirect_pc), 64'h1c00_8000);
      chk("sys_no_flush", 64'(ws_flush_pipe), 64'd0);
      if (i < 2) cyc();
    end
    chk("sys_instret", 64'(instret), 64'd1);
    handshake();
    // The ADD was still offered in the handshake cycle and must be gone.
    chk("sys_dropped_rf_we", 64'(ws_to_rf_we), 64'd0);
    clr_ms();

    // CSR exchange retires with read data into the RF
    begin
      rf_exp_t e;
      e.waddr = 5'd9; e.wdata = 32'hC5C5_0001;
      sb.push_back(e);
    end
    ms_pc = 32'h1c00_0018; ms_csr_re = 1; ms_csr_we = 1; ms_csr_num = 14'h5;
    ms_dest = 5'd9; ms_csr_wmask = 32'h0000_FFFF; ms_csr_wvalue = 32'h0000_ABCD;
    send();
    chk("xchg_csr_re", 64'(csr_re), 64'd1);
    chk("xchg_csr_we", 64'(csr_we), 64'd1);
    chk("xchg_csr_num", 64'(csr_num), 64'h5);
    chk("xchg_wmask", 64'(csr_wmask), 64'h0000_FFFF);
    chk("xchg_wvalue", 64'(csr_wvalue), 64'h0000_ABCD);
    cyc();
    chk("xchg_instret", 64'(instret), 64'd2);

    // Interrupt over CSRWR
    ms_pc = 32'h1c00_0020; ms_csr_re = 1; ms_csr_we = 1; ms_csr_num = 14'h6;
    ms_dest = 5'd3; ms_csr_wvalue = 32'h55; ms_ex = 1; ms_ecode = 6'h8; ms_esubcode = 9'h1;
    send();
    has_int = 1;
    #1;
    chk("int_wb_ex", 64'(wb_ex), 64'd1);
    chk("int_ecode", 64'(wb_ecode), 64'd0);
    chk("int_esub", 64'(wb_esubcode), 64'd0);
    chk("int_csr_we", 64'(csr_we), 64'd0);
    chk("int_rf_we", 64'(ws_to_rf_we), 64'd0);
    cyc();
    has_int = 0;
    chk("int_instret", 64'(instret), 64'd2);
    chk("int_redirect_pc", 64'(redirect_pc), 64'h1c00_8000);
    handshake();

    // ERTN, ready already high at T+1
    ms_pc = 32'h1c00_0030; ms_ertn = 1;
    send();
    chk("ertn_flush", 64'(ertn_flush), 64'd1);
    chk("ertn_wb_ex", 64'(wb_ex), 64'd0);
    chk("ertn_flush_pipe", 64'(ws_flush_pipe), 64'd1);
    chk("ertn_csr_re", 64'(csr_re), 64'd1);
    chk("ertn_rf_we", 64'(ws_to_rf_we), 64'd0);
    cyc();
    chk("ertn_instret", 64'(instret), 64'd3);
    chk("ertn_redirect_pc", 64'(redirect_pc), 64'h1c00_0044);
    handshake();
    send_add(32'h1c00_0044, 5'd4, 32'h44);
    cyc();
    chk("post_ertn_instret", 64'(instret), 64'd4);

    // Exception beats ERTN
    ms_pc = 32'h1c00_0048; ms_ertn = 1; ms_ex = 1; ms_ecode = 6'h8; ms_esubcode = 9'h1;
    send();
    chk("exertn_ertn_flush", 64'(ertn_flush), 64'd0);
    chk("exertn_wb_ex", 64'(wb_ex), 64'd1);
    chk("exertn_esub", 64'(wb_esubcode), 64'd1);
    cyc();
    chk("exertn_redirect_pc", 64'(redirect_pc), 64'h1c00_8000);
    handshake();

    // Counter wrap from a fresh reset
    reset = 1;
    cyc();
    reset = 0;
    chk("wrap_rst_instret", 64'(instret), 64'd0);
    for (int i = 1; i <= 17; i++) begin
      send_add(32'h1c00_1000 + 32'(4 * i), 5'(i), 32'(i * 3 + 1));
      if (i == 16) chk("wrap_instret_max", 64'(instret), 64'd15);
      if (i == 17) chk("wrap_instret_zero", 64'(instret), 64'd0);
    end
    cyc();
    chk("wrap_instret_one", 64'(instret), 64'd1);

    // Reset mid-REDIRECT
    ms_pc = 32'h1c00_2000; ms_ex = 1; ms_ecode = ECODE_SYS;
    send();
    cyc();
    chk("rr_redirect_valid", 64'(redirect_valid), 64'd1);
    reset = 1;
    cyc();
    reset = 0;
    chk("rr_redirect_valid_cleared", 64'(redirect_valid), 64'd0);
    chk("rr_redirect_pc", 64'(redirect_pc), 64'd0);
    send_add(32'h1c00_3000, 5'd2, 32'h77);
    chk("rr_rf_we", 64'(ws_to_rf_we), 64'd1);
    cyc();
    chk("rr_instret", 64'(instret), 64'd1);
    chk("sb_empty", 64'(sb.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
